// File: rtl/onewire_pkg.sv
// Shared 1-Wire definitions: standard timing constants (in microseconds) and
// the reset/presence sequencer state encoding.
package onewire_pkg;

    // Reset / presence timing
    localparam int OW_T_RSTL_US   = 480;
    localparam int OW_T_SAMPLE_US = 70;
    localparam int OW_T_RSTH_US   = 480;

    // Slot timing for the read/write slot blocks
    localparam int OW_T_SLOT_US   = 60;
    localparam int OW_T_LOW1_US   = 6;
    localparam int OW_T_LOW0_US   = 60;
    localparam int OW_T_RDV_US    = 15;
    localparam int OW_T_REC_US    = 1;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        RST_LOW     = 2'd1,
        WAIT_SAMPLE = 2'd2,
        RECOVER     = 2'd3
    } ow_state_t;

    function automatic int ow_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/onewire_us_tick.sv
// Microsecond time base: counts 0..CLKS_PER_US-1 and flags the last cycle of
// each microsecond. clr restarts the count so a new interval begins aligned.
module onewire_us_tick #(
    parameter int CLKS_PER_US = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic us_tick
);

    localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_US - 1);

    logic [PW-1:0] presc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
        end else if (clr || (presc_reg == PRESC_LAST)) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    // Depends only on the register, so the FSM may feed clr from its next state
    assign us_tick = (presc_reg == PRESC_LAST);

endmodule

// File: rtl/onewire_reset_master.sv
// 1-Wire bus master reset/presence sequencer: drives the reset pulse, releases
// the line, samples the slave presence pulse and flags a stuck-low bus.
module onewire_reset_master
    import onewire_pkg::*;
#(
    parameter int CLKS_PER_US = 1,
    parameter int T_RSTL_US   = OW_T_RSTL_US,
    parameter int T_SAMPLE_US = OW_T_SAMPLE_US,
    parameter int T_RSTH_US   = OW_T_RSTH_US
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bus_in,
    output logic bus_drive_low,
    output logic busy,
    output logic done,
    output logic presence,
    output logic bus_fault
);

    localparam int SYNC_STAGES  = 2;
    localparam int T_RECOVER_US = T_RSTH_US - T_SAMPLE_US;
    localparam int CNT_W        = $clog2(ow_max(T_RSTL_US, T_RSTH_US) + 1);

    localparam logic [CNT_W-1:0] RSTL_LAST    = CNT_W'(T_RSTL_US - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST  = CNT_W'(T_SAMPLE_US - 1);
    localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(T_RECOVER_US - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   bus_s;

    ow_state_t  state_reg, state_next;
    logic [CNT_W-1:0] us_cnt_reg, us_cnt_next;
    logic busy_reg, busy_next;
    logic drive_reg, drive_next;
    logic done_reg, done_next;
    logic presence_reg, presence_next;
    logic fault_reg, fault_next;
    logic us_tick;
    logic tick_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus_in};
        end
    end

    assign bus_s = sync_reg[SYNC_STAGES-1];

    onewire_us_tick #(
        .CLKS_PER_US (CLKS_PER_US)
    ) u_us_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tick_clr),
        .us_tick (us_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            us_cnt_reg   <= '0;
            busy_reg     <= 1'b0;
            drive_reg    <= 1'b0;
            done_reg     <= 1'b0;
            presence_reg <= 1'b0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            us_cnt_reg   <= us_cnt_next;
            busy_reg     <= busy_next;
            drive_reg    <= drive_next;
            done_reg     <= done_next;
            presence_reg <= presence_next;
            fault_reg    <= fault_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        busy_next     = busy_reg;
        drive_next    = drive_reg;
        done_next     = 1'b0;
        presence_next = presence_reg;
        fault_next    = fault_reg;
        us_cnt_next   = us_tick ? (us_cnt_reg + 1'b1) : us_cnt_reg;

        case (state_reg)
            IDLE: begin
                drive_next = 1'b0;
                if (start) begin
                    state_next    = RST_LOW;
                    busy_next     = 1'b1;
                    drive_next    = 1'b1;
                    presence_next = 1'b0;
                    fault_next    = 1'b0;
                end
            end
            RST_LOW: begin
                if (us_tick && (us_cnt_reg == RSTL_LAST)) begin
                    state_next = WAIT_SAMPLE;
                    drive_next = 1'b0;
                end
            end
            WAIT_SAMPLE: begin
                if (us_tick && (us_cnt_reg == SAMPLE_LAST)) begin
                    state_next    = RECOVER;
                    presence_next = ~bus_s;
                end
            end
            RECOVER: begin
                // A line still low after the whole recovery window means a shorted bus
                if (us_tick && (us_cnt_reg == RECOVER_LAST)) begin
                    state_next = IDLE;
                    fault_next = ~bus_s;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                drive_next = 1'b0;
            end
        endcase

        // Every interval starts from a fresh microsecond boundary
        tick_clr = (state_reg == IDLE) || (state_next != state_reg);
        if (tick_clr) begin
            us_cnt_next = '0;
        end
    end

    assign bus_drive_low = drive_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign presence      = presence_reg;
    assign bus_fault     = fault_reg;

endmodule
